// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, FSM states and counter limit for the PWM dead-time generator
package pwm_pkg;

    localparam int CW_DEF  = 15;
    localparam int DTW_DEF = 8;

    localparam logic [CW_DEF-1:0] CNT_MAX = {CW_DEF{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        HI_ON,
        LO_ON,
        DT_TO_HI,
        DT_TO_LO
    } pwm_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output FSM with programmable dead-time counter
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DTW = DTW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           raw_q,
    input  logic           out_en,
    input  logic [DTW-1:0] dead,
    output logic           pwm_h,
    output logic           pwm_l
);

    pwm_state_e     state, state_n, to_hi, to_lo;
    logic [DTW-1:0] cnt, cnt_n;

    // A zero dead time bypasses the DT states entirely.
    assign to_hi = (dead == '0) ? HI_ON : DT_TO_HI;
    assign to_lo = (dead == '0) ? LO_ON : DT_TO_LO;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (out_en) begin
                state_n = raw_q ? to_hi : to_lo;
                cnt_n   = dead;
            end
            HI_ON: if (!raw_q) begin
                state_n = to_lo;
                cnt_n   = dead;
            end
            LO_ON: if (raw_q) begin
                state_n = to_hi;
                cnt_n   = dead;
            end
            DT_TO_HI: if (!raw_q) begin
                state_n = to_lo;
                cnt_n   = dead;
            end else if (cnt <= DTW'(1)) begin
                state_n = HI_ON;
            end else begin
                cnt_n = cnt - DTW'(1);
            end
            DT_TO_LO: if (raw_q) begin
                state_n = to_hi;
                cnt_n   = dead;
            end else if (cnt <= DTW'(1)) begin
                state_n = LO_ON;
            end else begin
                cnt_n = cnt - DTW'(1);
            end
            default: state_n = IDLE;
        endcase
        if (!out_en) state_n = IDLE;
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pwm_h <= (state_n == HI_ON);
            pwm_l <= (state_n == LO_ON);
        end
    end

endmodule

// File: rtl/pwm_dt_gen.sv
// pwm_dt_gen: double-buffered duty compare driving complementary outputs with dead time
module pwm_dt_gen
    import pwm_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int DTW      = DTW_DEF,
    parameter int DEAD_DEF = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [CW-1:0]  count,
    input  logic           count_en,
    input  logic [CW-1:0]  duty_in,
    input  logic           duty_wr,
    input  logic [DTW-1:0] dead_in,
    input  logic           dead_wr,
    input  logic           out_en,
    output logic           pwm_h,
    output logic           pwm_l,
    output logic           period_end,
    output logic           duty_pending
);

    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic [CW-1:0]  duty_shadow, duty_active;
    logic [DTW-1:0] dead;
    logic           raw_q, boundary;

    assign boundary = (count == CMAX) && count_en;

    // A write on the boundary cycle still lands in the shadow; the old shadow is applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_shadow  <= '0;
            duty_active  <= '0;
            duty_pending <= 1'b0;
            period_end   <= 1'b0;
            dead         <= DTW'(DEAD_DEF);
            raw_q        <= 1'b0;
        end else begin
            period_end <= boundary;
            raw_q      <= count < duty_active;
            if (boundary && duty_pending) duty_active <= duty_shadow;
            if (duty_wr) begin
                duty_shadow  <= duty_in;
                duty_pending <= 1'b1;
            end else if (boundary) begin
                duty_pending <= 1'b0;
            end
            if (dead_wr) dead <= dead_in;
        end
    end

    pwm_deadtime #(.DTW(DTW)) u_dt (
        .clk   (clk),
        .reset (reset),
        .raw_q (raw_q),
        .out_en(out_en),
        .dead  (dead),
        .pwm_h (pwm_h),
        .pwm_l (pwm_l)
    );

endmodule

// File: tb/tb_pwm_dt_gen.sv
// tb_pwm_dt_gen: directed table and sequence checks for pwm_dt_gen
module tb_pwm_dt_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] count = '0;
    logic        count_en = 1'b0;
    logic [14:0] duty_in = '0;
    logic        duty_wr = 1'b0;
    logic [7:0]  dead_in = '0;
    logic        dead_wr = 1'b0;
    logic        out_en = 1'b0;
    logic        pwm_h, pwm_l, period_end, duty_pending;

    int n_cmp = 0;
    int n_fail = 0;
    int both_seen = 0;

    typedef struct {
        logic [14:0] duty;
        logic [14:0] cnt;
        logic        h;
        logic        l;
    } vec_t;

    vec_t tbl [10];

    pwm_dt_gen dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .count_en    (count_en),
        .duty_in     (duty_in),
        .duty_wr     (duty_wr),
        .dead_in     (dead_in),
        .dead_wr     (dead_wr),
        .out_en      (out_en),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .period_end  (period_end),
        .duty_pending(duty_pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pwm_h && pwm_l) both_seen = both_seen + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_out(input string nm, input logic h, input logic l, input int maxc, output int n);
        n = 0;
        while (!(pwm_h == h && pwm_l == l) && n < maxc) begin
            tick();
            n++;
        end
        chk({nm, "_reached"}, int'({pwm_h, pwm_l}), int'({h, l}));
    endtask

    task automatic apply_duty(input logic [14:0] d);
        duty_in = d;
        duty_wr = 1'b1;
        count_en = 1'b0;
        tick();
        duty_wr = 1'b0;
        count = 15'h7FFF;
        count_en = 1'b1;
        tick();
        count_en = 1'b0;
    endtask

    initial begin
        int n, hi_cnt, pe_cnt;
        tbl[0] = '{15'h0000, 15'h0000, 1'b0, 1'b1};
        tbl[1] = '{15'h0000, 15'h7FFF, 1'b0, 1'b1};
        tbl[2] = '{15'h7FFF, 15'h0000, 1'b1, 1'b0};
        tbl[3] = '{15'h7FFF, 15'h7FFE, 1'b1, 1'b0};
        tbl[4] = '{15'h7FFF, 15'h7FFF, 1'b0, 1'b1};
        tbl[5] = '{15'h4000, 15'h3FFF, 1'b1, 1'b0};
        tbl[6] = '{15'h4000, 15'h4000, 1'b0, 1'b1};
        tbl[7] = '{15'h0001, 15'h0000, 1'b1, 1'b0};
        tbl[8] = '{15'h0001, 15'h0001, 1'b0, 1'b1};
        tbl[9] = '{15'h1000, 15'h0FFF, 1'b1, 1'b0};

        ticks(2);
        chk("rst_h", pwm_h, 0);
        chk("rst_l", pwm_l, 0);
        chk("rst_period_end", period_end, 0);
        chk("rst_pending", duty_pending, 0);
        reset = 1'b0;

        // Default dead time of 4: enable, then symmetric transitions.
        duty_in = 15'h4000;
        duty_wr = 1'b1;
        tick();
        duty_wr = 1'b0;
        chk("wr_pending", duty_pending, 1);
        count = 15'h7FFF;
        count_en = 1'b1;
        tick();
        chk("bnd_period_end", period_end, 1);
        chk("bnd_pending_clr", duty_pending, 0);
        count = '0;
        count_en = 1'b0;
        ticks(2);
        chk("pe_one_cycle", period_end, 0);
        out_en = 1'b1;
        wait_out("en_hi", 1'b1, 1'b0, 20, n);
        chk("en_first_drive_clks", n, 5);
        count = 15'h4000;
        wait_out("h_fall", 1'b0, 1'b0, 20, n);
        chk("h_fall_clks", n, 2);
        wait_out("l_rise", 1'b0, 1'b1, 20, n);
        chk("dead4_lo_clks", n, 4);
        count = '0;
        wait_out("l_fall", 1'b0, 1'b0, 20, n);
        chk("l_fall_clks", n, 2);
        wait_out("h_rise", 1'b1, 1'b0, 20, n);
        chk("dead4_hi_clks", n, 4);

        // Dead time 0: compare table with direct switching.
        dead_in = 8'd0;
        dead_wr = 1'b1;
        tick();
        dead_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            count = '0;
            apply_duty(tbl[i].duty);
            count = tbl[i].cnt;
            ticks(3);
            chk($sformatf("tbl%0d_h", i), pwm_h, int'(tbl[i].h));
            chk($sformatf("tbl%0d_l", i), pwm_l, int'(tbl[i].l));
        end
        count = 15'h0FFF;
        ticks(1);
        count = 15'h1000;
        wait_out("dead0", 1'b0, 1'b1, 10, n);
        chk("dead0_latency", n, 2);

        // Double buffer: write mid-period, takes effect only after the wrap.
        count = 15'h0100;
        duty_in = 15'h2000;
        duty_wr = 1'b1;
        tick();
        duty_wr = 1'b0;
        chk("db_pending", duty_pending, 1);
        count = 15'h1800;
        ticks(3);
        chk("db_old_duty_h", pwm_h, 0);
        chk("db_still_pending", duty_pending, 1);
        count = 15'h7FFF;
        count_en = 1'b1;
        tick();
        pe_cnt = int'(period_end);
        hi_cnt = 0;
        for (int c = 0; c < 15'h2100; c++) begin
            count = 15'(c);
            tick();
            hi_cnt += int'(pwm_h);
            pe_cnt += int'(period_end);
            if (c == 0) chk("db_pending_clr", duty_pending, 0);
        end
        count_en = 1'b0;
        chk("db_high_width", hi_cnt, 'h2000);
        chk("db_period_end_pulses", pe_cnt, 1);

        // Write landing on the boundary cycle.
        duty_in = 15'h3000;
        duty_wr = 1'b1;
        tick();
        duty_in = 15'h0800;
        count = 15'h7FFF;
        count_en = 1'b1;
        tick();
        duty_wr = 1'b0;
        count_en = 1'b0;
        chk("bw_pending_kept", duty_pending, 1);
        count = 15'h2800;
        ticks(3);
        chk("bw_uses_3000_h", pwm_h, 1);
        count = 15'h3000;
        ticks(3);
        chk("bw_3000_edge_h", pwm_h, 0);
        chk("bw_pending_period", duty_pending, 1);
        count = 15'h7FFF;
        count_en = 1'b1;
        tick();
        count_en = 1'b0;
        chk("bw_pending_clr", duty_pending, 0);
        count = 15'h07FF;
        ticks(3);
        chk("bw_uses_0800_h", pwm_h, 1);
        count = 15'h0800;
        ticks(3);
        chk("bw_0800_edge_h", pwm_h, 0);

        // Dead time 6, then a raw glitch during DT_TO_HI.
        dead_in = 8'd6;
        dead_wr = 1'b1;
        tick();
        dead_wr = 1'b0;
        count = '0;
        wait_out("d6_hi", 1'b1, 1'b0, 30, n);
        chk("d6_hi_latency", n, 8);
        count = 15'h0800;
        wait_out("d6_lo", 1'b0, 1'b1, 30, n);
        chk("d6_lo_latency", n, 8);
        count = '0;
        ticks(4);
        chk("glitch_in_dt", int'({pwm_h, pwm_l}), 0);
        count = 15'h1000;
        wait_out("glitch_back_lo", 1'b0, 1'b1, 30, n);
        chk("glitch_reload_clks", n, 8);

        // out_en drop mid-HI_ON and re-assert.
        count = '0;
        wait_out("oe_hi", 1'b1, 1'b0, 30, n);
        out_en = 1'b0;
        tick();
        chk("oe_drop_outs", int'({pwm_h, pwm_l}), 0);
        ticks(2);
        out_en = 1'b1;
        wait_out("oe_reassert", 1'b1, 1'b0, 30, n);
        chk("oe_reassert_clks", n, 7);

        // Reset in the middle of a dead interval.
        count = 15'h1000;
        duty_in = 15'h5555;
        duty_wr = 1'b1;
        tick();
        duty_wr = 1'b0;
        ticks(2);
        chk("mid_dt_outs", int'({pwm_h, pwm_l}), 0);
        reset = 1'b1;
        tick();
        chk("rst2_outs", int'({pwm_h, pwm_l}), 0);
        chk("rst2_pending", duty_pending, 0);
        chk("rst2_period_end", period_end, 0);
        reset = 1'b0;
        count = '0;
        wait_out("rst2_lo", 1'b0, 1'b1, 20, n);
        chk("rst2_dead_def_clks", n, 5);
        ticks(4);
        chk("rst2_duty_zero_h", pwm_h, 0);

        chk("never_both_high", both_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_dt_gen.md
Name: pwm_dt_gen

Overview:
- Downstream consumer of the 15-bit free-running PWM counter (F_out, enable).
- Compares the count against a double-buffered duty value to form the raw PWM level.
- Drives complementary high-side/low-side outputs with programmable dead time.
- Double-buffering guarantees duty changes take effect only on a period boundary, so no glitching partial periods.

Parameters:
- CW, 15, counter/duty width; must match the upstream counter width.
- DTW, 8, dead-time register width in clocks.
- DEAD_DEF, 4, dead-time value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- count  in  CW  current counter value (upstream F_out)
- count_en  in  1  upstream enable; count advances on this edge when 1
- duty_in  in  CW  new duty value
- duty_wr  in  1  one-cycle strobe; writes duty_in to shadow
- dead_in  in  DTW  new dead-time value
- dead_wr  in  1  one-cycle strobe; writes dead_in immediately
- out_en  in  1  output enable; 0 forces both outputs low
- pwm_h  out  1  high-side drive
- pwm_l  out  1  low-side drive
- period_end  out  1  one-cycle pulse at each period wrap
- duty_pending  out  1  shadow holds a value not yet applied

Behaviour:
- One clock domain; all state changes on rising clk; reset synchronous, active-high.
- Reset values:
  - pwm_h=0, pwm_l=0, period_end=0, duty_pending=0.
  - duty_shadow=0, duty_active=0, dead=DEAD_DEF, raw_q=0, FSM=IDLE.
- Duty write:
  - duty_wr=1 → duty_shadow<=duty_in, duty_pending<=1.
- Boundary:
  - Boundary cycle = (count==2^CW-1) && count_en.
  - On the boundary cycle: period_end<=1 for one cycle.
  - If duty_pending, duty_active<=duty_shadow and duty_pending<=0.
- Write on a boundary cycle:
  - duty_active takes the old shadow (if pending).
  - duty_shadow takes duty_in; duty_pending stays 1.
  - The new value applies at the next boundary.
- Compare:
  - raw_q <= (count < duty_active), unsigned CW-bit compare, registered (1 clk latency).
  - duty 0 → raw always 0.
  - duty 2^CW-1 → raw 0 only at count 2^CW-1.
  - No 100% duty.
- Dead time:
  - dead_wr → dead<=dead_in next clk.
  - A new value affects dead intervals started afterwards; an interval in progress keeps its loaded count.
- FSM states and outputs:
  - IDLE: h=0, l=0.
  - HI_ON: h=1, l=0.
  - LO_ON: h=0, l=1.
  - DT_TO_HI: h=0, l=0.
  - DT_TO_LO: h=0, l=0.
  - Outputs are registered decodes of state.
- FSM transitions:
  - IDLE, out_en=1 → DT_TO_HI if raw_q else DT_TO_LO; dead counter loads dead.
  - HI_ON, raw_q=0 → DT_TO_LO.
  - LO_ON, raw_q=1 → DT_TO_HI.
  - DT_x: counter decrements each clk; at 1 → x_ON.
  - DT_x, raw_q flips to the opposite level during dead time → switch to the other DT state with the counter reloaded (full dead time again).
  - dead==0: skip DT states; HI_ON↔LO_ON directly, and IDLE→x_ON directly.
  - out_en=0 in any state → IDLE next clk, regardless of dead-time progress.
- Latency:
  - The edge where count first satisfies count<duty_active → pwm_h rises 2+dead clks later.
  - pwm_h and pwm_l are never 1 in the same cycle under any input sequence.
- count_en=0: count frozen; compare and FSM keep running on the frozen value; no boundary occurs.
- Reset mid-operation: all state returns to reset values next clk; both outputs 0 immediately after.

Decomposition:
- Shared package pwm_pkg holds:
  - CW and DTW defaults.
  - FSM state enumeration (IDLE, HI_ON, LO_ON, DT_TO_HI, DT_TO_LO).
  - Constant CNT_MAX = 2^CW-1.
- One sub-module: pwm_deadtime, containing the FSM plus dead counter.
  - Inputs: raw_q, out_en, dead.
  - Outputs: pwm_h, pwm_l.
- Compare and duty double-buffer stay in the top level.

Test Plan:
- Reset default: after reset, out_en=1, duty=0x4000 written and applied, count sweeping → pwm_h/pwm_l alternate, each separated by exactly 4 clks of both-low; never both high.
- Double buffer: with duty_active=0x1000, write 0x2000 at count=0x0100 → duty_pending=1; high time unchanged until count=0x7FFF; the next period's high width is 0x2000 counts; period_end pulses once; duty_pending clears.
- Write on boundary: pending 0x3000; write 0x0800 on the boundary cycle → the next period uses 0x3000, the following period uses 0x0800; duty_pending stays 1 through the first period.
- Extremes: duty 0 → pwm_h never 1, pwm_l steady 1. duty 0x7FFF → pwm_l pulses only around count 0x7FFF, bracketed by dead time.
- Dead-time edge cases:
  - dead=0 → direct h↔l switch, 2-clk latency from count.
  - dead=6 with a raw glitch 3 clks into DT_TO_HI → returns via DT_TO_LO with a full 6-clk dead interval.
- Enable/reset: drop out_en mid-HI_ON → both low next clk. Re-assert → first drive after a full dead interval. Assert reset mid-DT → all outputs 0, duty_active 0, dead=4.
